// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use hazard detection, EX/MEM and MEM/WB
// operand forwarding, and ALU operation decode for the 64-bit EX stage.
module id_ex_operand_stage #(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [1:0]       id_aluop,
  input  logic [3:0]       id_funct,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_branch,
  input  logic             flush,
  input  logic             hold,
  input  logic             exmem_regwrite,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_regwrite,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [XLEN-1:0]  memwb_data,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_op,
  output logic [XLEN-1:0]  store_data,
  output logic             ex_valid,
  output logic [RA_W-1:0]  ex_rd,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_branch,
  output logic [XLEN-1:0]  ex_imm,
  output logic             stall_id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [1:0]      ex_aluop;
  logic [3:0]      ex_funct;
  logic            ex_alusrc;
  logic            load_in_ex;
  logic            load_bubble;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  assign load_in_ex = ex_valid && ex_memread && (ex_rd != '0);

  always_comb begin
    stall_id = load_in_ex && id_valid && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    if (flush || hold) stall_id = 1'b0;
  end

  // Flush beats hold; hold beats a stall or an empty ID slot.
  assign load_bubble = reset || flush || (!hold && (stall_id || !id_valid));

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      ex_valid    <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_aluop    <= 2'b00;
      ex_funct    <= 4'b0000;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_branch   <= 1'b0;
    end else if (!hold) begin
      ex_valid    <= 1'b1;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_aluop    <= id_aluop;
      ex_funct    <= id_funct;
      ex_alusrc   <= id_alusrc;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_memtoreg <= id_memtoreg;
      ex_branch   <= id_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_id && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_rs1))
      fwd_rs1 = exmem_result;
    else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_rs1))
      fwd_rs1 = memwb_data;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data;
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_rs2))
      fwd_rs2 = exmem_result;
    else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_rs2))
      fwd_rs2 = memwb_data;
  end

  assign alu_a      = fwd_rs1;
  assign alu_b      = ex_alusrc ? ex_imm : fwd_rs2;
  assign store_data = fwd_rs2;

  always_comb begin
    alu_op = 4'b1111;
    case (ex_aluop)
      2'b00: alu_op = 4'b0010;
      2'b01: alu_op = 4'b0110;
      2'b10: begin
        case (ex_funct)
          4'b0000: alu_op = 4'b0010;
          4'b1000: alu_op = 4'b0110;
          4'b0111: alu_op = 4'b0000;
          4'b0110: alu_op = 4'b0001;
          4'b0001: alu_op = 4'b1000;
          default: alu_op = 4'b1111;
        endcase
      end
      default: alu_op = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: a behavioural model of the EX slot checked
// every cycle, plus directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm;
  logic [1:0]  id_aluop;
  logic [3:0]  id_funct;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch;
  logic        flush, hold;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [63:0] exmem_result, memwb_data;
  logic [63:0] alu_a, alu_b, store_data, ex_imm;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;
  logic [4:0]  ex_rd;
  logic        stall_id;
  logic [31:0] stall_cnt, flush_cnt;

  int ncmp = 0;
  int nerr = 0;
  bit cmp_en = 1'b0;

  always #10 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_aluop(id_aluop), .id_funct(id_funct),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_branch(id_branch),
    .flush(flush), .hold(hold),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .store_data(store_data),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .ex_imm(ex_imm),
    .stall_id(stall_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of the instruction sitting in EX; v=0 means the slot holds a bubble.
  typedef struct {
    bit v; bit [4:0] rs1, rs2, rd; bit [63:0] d1, d2, imm;
    bit [1:0] aluop; bit [3:0] funct; bit alusrc, rw, mr, mw, mt, br;
  } instr_t;

  instr_t m;
  bit [31:0] m_sc, m_fc;

  function automatic instr_t empty_slot();
    instr_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic bit exp_stall();
    bit dep;
    dep = m.v && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
    return dep && !flush && !hold;
  endfunction

  function automatic bit [63:0] operand(bit [4:0] rs, bit [63:0] regval);
    if (rs == 0) return regval;
    if (exmem_regwrite && exmem_rd == rs) return exmem_result;
    if (memwb_regwrite && memwb_rd == rs) return memwb_data;
    return regval;
  endfunction

  function automatic bit [3:0] exp_op(bit [1:0] aluop, bit [3:0] funct);
    bit [3:0] rtype [16];
    foreach (rtype[i]) rtype[i] = 4'hF;
    rtype[4'b0000] = 4'b0010;  // add
    rtype[4'b1000] = 4'b0110;  // sub
    rtype[4'b0111] = 4'b0000;  // and
    rtype[4'b0110] = 4'b0001;  // or
    rtype[4'b0001] = 4'b1000;  // sll
    if (aluop == 2'b00) return 4'b0010;
    if (aluop == 2'b01) return 4'b0110;
    if (aluop == 2'b10) return rtype[funct];
    return 4'hF;
  endfunction

  initial begin
    m = empty_slot();
    m_sc = 0;
    m_fc = 0;
  end

  always @(posedge clk) begin
    bit st;
    st = exp_stall();
    if (reset) begin
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (st && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (flush && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    end
    if (reset || flush) m = empty_slot();
    else if (hold) m = m;
    else if (st || !id_valid) m = empty_slot();
    else begin
      m.v = 1; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
      m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm;
      m.aluop = id_aluop; m.funct = id_funct; m.alusrc = id_alusrc;
      m.rw = id_regwrite; m.mr = id_memread; m.mw = id_memwrite;
      m.mt = id_memtoreg; m.br = id_branch;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_alu_a", alu_a, operand(m.rs1, m.d1));
      chk("m_alu_b", alu_b, m.alusrc ? m.imm : operand(m.rs2, m.d2));
      chk("m_store_data", store_data, operand(m.rs2, m.d2));
      chk("m_alu_op", alu_op, exp_op(m.aluop, m.funct));
      chk("m_ex_valid", ex_valid, m.v);
      chk("m_ex_rd", ex_rd, m.rd);
      chk("m_ex_ctrl", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch},
          {m.rw, m.mr, m.mw, m.mt, m.br});
      chk("m_ex_imm", ex_imm, m.imm);
      chk("m_stall_id", stall_id, exp_stall());
      chk("m_stall_cnt", stall_cnt, m_sc);
      chk("m_flush_cnt", flush_cnt, m_fc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_aluop = 0; id_funct = 0;
    id_alusrc = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    id_memtoreg = 0; id_branch = 0; flush = 0; hold = 0;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic rtype(input bit [4:0] rs1, rs2, rd, input bit [63:0] d1, d2,
                       input bit [3:0] funct);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_aluop = 2'b10; id_funct = funct;
    id_regwrite = 1; id_alusrc = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
  endtask

  task automatic load(input bit [4:0] rs1, rd, input bit [63:0] imm);
    id_valid = 1; id_rs1 = rs1; id_rs2 = 0; id_rd = rd; id_imm = imm;
    id_rs1_data = 64'h100; id_aluop = 2'b00; id_alusrc = 1;
    id_regwrite = 1; id_memread = 1; id_memtoreg = 1;
  endtask

  bit [1:0] tv_aluop [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
  bit [3:0] tv_funct [8] = '{4'h7, 4'h6, 4'h8, 4'h3, 4'h0, 4'h0, 4'h0, 4'hF};
  bit [3:0] tv_op    [8] = '{4'h0, 4'h1, 4'h6, 4'hF, 4'h6, 4'hF, 4'h2, 4'hF};

  initial begin
    idle();
    // Reset with every input active.
    reset = 1;
    rtype(5'd1, 5'd2, 5'd3, 64'hFF, 64'hEE, 4'h0);
    id_imm = 64'h55; id_memread = 1; id_memwrite = 1; id_memtoreg = 1; id_branch = 1;
    flush = 1; hold = 1;
    exmem_regwrite = 1; exmem_rd = 5'd1; exmem_result = 64'hAA;
    memwb_regwrite = 1; memwb_rd = 5'd2; memwb_data = 64'hBB;
    tick(); tick();
    cmp_en = 1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_store_data", store_data, 0);
    chk("rst_alu_op", alu_op, 4'b0010);
    chk("rst_ex_regwrite", ex_regwrite, 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_stall_id", stall_id, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    reset = 0;
    idle();

    // add x3 = x1 + x2
    rtype(5'd1, 5'd2, 5'd3, 64'd5, 64'd7, 4'h0);
    tick();
    chk("add_alu_a", alu_a, 64'd5);
    chk("add_alu_b", alu_b, 64'd7);
    chk("add_alu_op", alu_op, 4'b0010);
    chk("add_ex_rd", ex_rd, 5'd3);

    // Forwarding priority and x0 exclusion.
    idle();
    rtype(5'd1, 5'd2, 5'd3, 64'h111, 64'h222, 4'h0);
    tick();
    idle();
    exmem_regwrite = 1; exmem_rd = 5'd1; exmem_result = 64'h10;
    memwb_regwrite = 1; memwb_rd = 5'd1; memwb_data = 64'h20;
    #1 chk("fwd_exmem_prio", alu_a, 64'h10);
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1 chk("fwd_x0_regval", alu_a, 64'h111);
    memwb_rd = 5'd1;
    #1 chk("fwd_memwb", alu_a, 64'h20);
    exmem_rd = 5'd2;
    #1 chk("fwd_rs2_exmem", alu_b, 64'h10);

    // Load-use hazard: one bubble, then re-entry with MEM/WB forwarding.
    idle();
    load(5'd5, 5'd4, 64'd16);
    tick();
    idle();
    rtype(5'd6, 5'd4, 5'd7, 64'd1, 64'h99, 4'h0);
    #1 chk("lu_stall_id", stall_id, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_regwrite", ex_regwrite, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_stall_drop", stall_id, 0);
    tick();
    memwb_regwrite = 1; memwb_rd = 5'd4; memwb_data = 64'h77;
    #1 chk("lu_reentry_rd", ex_rd, 5'd7);
    chk("lu_reentry_a", alu_a, 64'd1);
    chk("lu_reentry_b", alu_b, 64'h77);

    // Hold keeps EX; hold and flush both suppress the stall.
    idle();
    rtype(5'd1, 5'd1, 5'd9, 64'd3, 64'd3, 4'h0);
    hold = 1;
    tick();
    chk("hold_keeps_rd", ex_rd, 5'd7);
    idle();
    load(5'd5, 5'd4, 64'd0);
    tick();
    idle();
    rtype(5'd4, 5'd2, 5'd8, 64'd1, 64'd2, 4'h0);
    hold = 1;
    #1 chk("hold_no_stall", stall_id, 0);
    flush = 1;
    tick();
    chk("flush_bubble", ex_valid, 0);
    chk("flush_cnt_1", flush_cnt, 1);
    chk("flush_stall_cnt", stall_cnt, 1);

    // sw with immediate offset and forwarded store data; then sll.
    idle();
    id_valid = 1; id_rs1 = 5'd2; id_rs2 = 5'd9; id_imm = 64'd8; id_alusrc = 1;
    id_memwrite = 1; id_aluop = 2'b00; id_rs1_data = 64'h1000; id_rs2_data = 64'd5;
    tick();
    idle();
    exmem_regwrite = 1; exmem_rd = 5'd9; exmem_result = 64'hAB;
    #1 chk("sw_alu_b", alu_b, 64'd8);
    chk("sw_store_data", store_data, 64'hAB);
    chk("sw_alu_a", alu_a, 64'h1000);
    chk("sw_ex_memwrite", ex_memwrite, 1);
    idle();
    rtype(5'd1, 5'd2, 5'd5, 64'd1, 64'd3, 4'b0001);
    tick();
    chk("sll_alu_op", alu_op, 4'b1000);

    for (int i = 0; i < 8; i++) begin
      idle();
      rtype(5'd1, 5'd2, 5'd3, 64'd1, 64'd2, tv_funct[i]);
      id_aluop = tv_aluop[i];
      tick();
      chk($sformatf("op_table_%0d", i), alu_op, tv_op[i]);
    end

    // Reset asserted while a load-use stall is pending.
    idle();
    load(5'd5, 5'd4, 64'd0);
    tick();
    idle();
    rtype(5'd1, 5'd4, 5'd6, 64'd1, 64'd2, 4'h0);
    #1 chk("rmid_stall_before", stall_id, 1);
    reset = 1;
    tick();
    chk("rmid_stall_after", stall_id, 0);
    chk("rmid_ex_valid", ex_valid, 0);
    chk("rmid_stall_cnt", stall_cnt, 0);
    reset = 0;

    // Mixed traffic with a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      idle();
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_rd  = 5'($urandom_range(0, 3));
      id_rs1_data = {$urandom, $urandom};
      id_rs2_data = {$urandom, $urandom};
      id_imm = {$urandom, $urandom};
      id_aluop = 2'($urandom_range(0, 3));
      id_funct = 4'($urandom_range(0, 15));
      {id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch} = 6'($urandom);
      exmem_regwrite = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 3));
      exmem_result = {$urandom, $urandom};
      memwb_regwrite = 1'($urandom);
      memwb_rd = 5'($urandom_range(0, 3));
      memwb_data = {$urandom, $urandom};
      tick();
    end
    reset = 0;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
